// File: rtl/des_key_schedule.sv
`timescale 1ns/1ps
// des_key_schedule
//   Iterative DES key schedule. Accepts one 64-bit key (parity bits included)
//   per request and produces the 16 48-bit round keys, one per clock, into a
//   register bank. The bank drives every round's key in parallel. When the
//   request carries decrypt_i=1 the keys are stored in reverse order, so an
//   unmodified round pipeline performs decryption.
// Ports
//   clk           clock, all state on the rising edge
//   rstn          asynchronous active-low reset
//   key_i         DES key, bit 63 = DES bit 1 (MSB-first FIPS numbering)
//   decrypt_i     sampled with key_i; 1 = store round keys in reverse order
//   key_valid_i   request strobe for key_i/decrypt_i
//   key_ready_o   block can accept a key (IDLE or DONE)
//   busy_o        generation in progress (GEN)
//   keys_valid_o  bank holds the complete schedule for the last accepted key
//   round_keys_o  round key r (0..15) at [48*r+47 : 48*r]
module des_key_schedule #(
  parameter int unsigned NUM_ROUNDS        = 16,
  parameter bit          ZERO_BANK_ON_LOAD = 1'b1
) (
  input  logic                       clk,
  input  logic                       rstn,
  input  logic [63:0]                key_i,
  input  logic                       decrypt_i,
  input  logic                       key_valid_i,
  output logic                       key_ready_o,
  output logic                       busy_o,
  output logic                       keys_valid_o,
  output logic [48*NUM_ROUNDS-1:0]   round_keys_o
);

  localparam int unsigned KEY_W = 64;
  localparam int unsigned CD_W  = 28;
  localparam int unsigned RK_W  = 48;
  localparam int unsigned CNT_W = 4;

  // The shift schedule and counter width only describe a 16-round schedule.
  if (NUM_ROUNDS != 16) begin : g_bad_rounds
    $error("des_key_schedule: NUM_ROUNDS must be 16");
  end

  // Permuted choice 1: FIPS source bit for each of the 56 C/D bits (C first).
  localparam int unsigned PC1_TAB [56] = '{
    57, 49, 41, 33, 25, 17,  9,  1, 58, 50, 42, 34, 26, 18,
    10,  2, 59, 51, 43, 35, 27, 19, 11,  3, 60, 52, 44, 36,
    63, 55, 47, 39, 31, 23, 15,  7, 62, 54, 46, 38, 30, 22,
    14,  6, 61, 53, 45, 37, 29, 21, 13,  5, 28, 20, 12,  4
  };

  // Permuted choice 2: source bit of {C,D} for each of the 48 round-key bits.
  localparam int unsigned PC2_TAB [48] = '{
    14, 17, 11, 24,  1,  5,  3, 28, 15,  6, 21, 10,
    23, 19, 12,  4, 26,  8, 16,  7, 27, 20, 13,  2,
    41, 52, 31, 37, 47, 55, 30, 40, 51, 45, 33, 48,
    44, 49, 39, 56, 34, 53, 46, 42, 50, 36, 29, 32
  };

  function automatic logic [2*CD_W-1:0] pc1(input logic [KEY_W-1:0] k);
    logic [2*CD_W-1:0] r;
    r = '0;
    for (int i = 0; i < 56; i++) begin
      r[6'(55 - i)] = k[6'(64 - PC1_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [RK_W-1:0] pc2(input logic [2*CD_W-1:0] cd);
    logic [RK_W-1:0] r;
    r = '0;
    for (int i = 0; i < 48; i++) begin
      r[6'(47 - i)] = cd[6'(56 - PC2_TAB[i])];
    end
    return r;
  endfunction

  function automatic logic [CD_W-1:0] rotl(input logic [CD_W-1:0] x, input logic two);
    return two ? {x[CD_W-3:0], x[CD_W-1:CD_W-2]} : {x[CD_W-2:0], x[CD_W-1]};
  endfunction

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_GEN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q;
  logic [CD_W-1:0]    c_q, d_q;
  logic               dec_q;
  logic [RK_W-1:0]    bank_q [NUM_ROUNDS];
  logic               ready_q, busy_q, valid_q;

  logic               accept;
  logic               gen_step;
  logic               shift_two;
  logic [CD_W-1:0]    c_rot, d_rot;
  logic [CNT_W-1:0]   wr_idx;

  // State register
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) state_q <= S_IDLE;
    else       state_q <= state_d;
  end

  // Next state and per-cycle datapath controls
  always_comb begin
    state_d   = state_q;
    accept    = 1'b0;
    gen_step  = 1'b0;
    shift_two = 1'b1;
    c_rot     = c_q;
    d_rot     = d_q;
    wr_idx    = cnt_q;

    // Single-bit rotation at iterations 1, 2, 9 and 16 (cnt 0, 1, 8, 15).
    if (cnt_q == CNT_W'(0) || cnt_q == CNT_W'(1) ||
        cnt_q == CNT_W'(8) || cnt_q == CNT_W'(15)) begin
      shift_two = 1'b0;
    end
    c_rot  = rotl(c_q, shift_two);
    d_rot  = rotl(d_q, shift_two);
    wr_idx = dec_q ? (CNT_W'(NUM_ROUNDS - 1) - cnt_q) : cnt_q;

    case (state_q)
      S_IDLE: begin
        if (key_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = S_GEN;
        end
      end
      S_GEN: begin
        gen_step = 1'b1;
        if (cnt_q == CNT_W'(NUM_ROUNDS - 1)) state_d = S_DONE;
      end
      S_DONE: begin
        if (key_valid_i && ready_q) begin
          accept  = 1'b1;
          state_d = S_GEN;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Status outputs registered from the next state, so they follow state exactly
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      ready_q <= (state_d != S_GEN);
      busy_q  <= (state_d == S_GEN);
      valid_q <= (state_d == S_DONE);
    end
  end

  // Key load, C/D rotation and bank writes
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      cnt_q <= '0;
      c_q   <= '0;
      d_q   <= '0;
      dec_q <= 1'b0;
      for (int r = 0; r < int'(NUM_ROUNDS); r++) bank_q[r] <= '0;
    end else if (accept) begin
      {c_q, d_q} <= pc1(key_i);
      dec_q      <= decrypt_i;
      cnt_q      <= '0;
      if (ZERO_BANK_ON_LOAD) begin
        for (int r = 0; r < int'(NUM_ROUNDS); r++) bank_q[r] <= '0;
      end
    end else if (gen_step) begin
      c_q            <= c_rot;
      d_q            <= d_rot;
      bank_q[wr_idx] <= pc2({c_rot, d_rot});
      cnt_q          <= cnt_q + CNT_W'(1);
    end
  end

  assign key_ready_o  = ready_q;
  assign busy_o       = busy_q;
  assign keys_valid_o = valid_q;

  // Bank registers wired straight to the round stages
  for (genvar r = 0; r < int'(NUM_ROUNDS); r++) begin : g_out
    assign round_keys_o[RK_W*r +: RK_W] = bank_q[r];
  end

endmodule
